led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl_if.sv | 27 ++
 rtl/led_mode_ctrl.sv | 173 +++++++++++++++++
 tb/tb_led_mode_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_mode_ctrl_if.sv
// LED mode controller bus: button sources, source select, auto-rotation
// controls and the registered mode/color/source outputs.
interface led_mode_ctrl_if #(
  parameter int unsigned NB_BTN = 4
);
  logic [NB_BTN-1:0] i_hw_btn;
  logic [NB_BTN-1:0] i_vio_btn;
  logic              i_sel_remote;
  logic              i_tick;
  logic              i_auto;
  logic              o_mode;
  logic [2:0]        o_color;
  logic              o_src;
  logic [3:0]        o_status;

  // Stimulus side (board wrapper or testbench).
  modport master (
    output i_hw_btn, i_vio_btn, i_sel_remote, i_tick, i_auto,
    input  o_mode, o_color, o_src, o_status
  );

  // Controller side.
  modport slave (
    input  i_hw_btn, i_vio_btn, i_sel_remote, i_tick, i_auto,
    output o_mode, o_color, o_src, o_status
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: picks one of two button sources (board or remote),
// turns rising edges of the granted source into mode/color commands, and
// optionally rotates the color on prescaler ticks.
// Optional hardware-button debounce is enabled by defining
// LED_MODE_CTRL_DEBOUNCE_EN; without it the synchronized level is used as is.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_TICKS      = 8,
  parameter int unsigned NB_BTN          = 4
) (
  input  logic           clock,
  input  logic           reset,
  led_mode_ctrl_if.slave io_led
);

  localparam int unsigned TW = $clog2(AUTO_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_TICKS - 1);

  typedef enum logic [1:0] {
    StGrantHw,
    StGrantRemote,
    StSwitchPending
  } arb_state_e;

  logic [NB_BTN-1:0] r_hw_sync1, r_hw_sync2;
  logic [1:0]        r_hw_vld;
  logic [NB_BTN-1:0] w_hw_lvl;
  logic [NB_BTN-1:0] r_hw_prev, r_hw_arm, w_hw_press;
  logic [NB_BTN-1:0] r_vio_prev, r_vio_arm, w_vio_press;
  logic [NB_BTN-1:0] w_press;
  arb_state_e        r_state, w_state_d;
  logic              r_src, w_src_d;
  logic              r_mode, w_mode_d;
  logic [2:0]        r_color, w_color_d;
  logic [TW-1:0]     r_tick_cnt, w_tick_cnt_d;

  // Two-flop synchronizer for the board buttons; r_hw_vld marks when r_hw_sync2
  // reflects a real post-reset sample of the pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hw_sync1 <= '0;
      r_hw_sync2 <= '0;
      r_hw_vld   <= 2'd0;
    end else begin
      r_hw_sync1 <= io_led.i_hw_btn;
      r_hw_sync2 <= r_hw_sync1;
      if (r_hw_vld != 2'd2) r_hw_vld <= r_hw_vld + 2'd1;
    end
  end

`ifdef LED_MODE_CTRL_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [NB_BTN-1:0] r_hw_filt;
  logic [DW-1:0]     r_db_cnt [NB_BTN];

  // Per-bit debounce: flip the filtered level after DEBOUNCE_CYCLES differing cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hw_filt <= '0;
      for (int unsigned i = 0; i < NB_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_BTN; i++) begin
        if (r_hw_sync2[i] == r_hw_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_hw_filt[i] <= r_hw_sync2[i];
          r_db_cnt[i]  <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_hw_lvl = r_hw_filt;
`else
  assign w_hw_lvl = r_hw_sync2;
`endif

  // A button held through reset stays disarmed until it has been seen released,
  // so it cannot produce a press until pressed again.
  assign w_hw_press  = w_hw_lvl & ~r_hw_prev & r_hw_arm;
  assign w_vio_press = io_led.i_vio_btn & ~r_vio_prev & r_vio_arm;

  // Edge history and arming for both sources.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hw_prev  <= '0;
      r_hw_arm   <= '0;
      r_vio_prev <= '0;
      r_vio_arm  <= ~io_led.i_vio_btn;
    end else begin
      r_hw_prev  <= w_hw_lvl;
      r_hw_arm   <= r_hw_arm | (~r_hw_sync2 & {NB_BTN{r_hw_vld == 2'd2}});
      r_vio_prev <= io_led.i_vio_btn;
      r_vio_arm  <= r_vio_arm | ~io_led.i_vio_btn;
    end
  end

  // Source arbiter next state; only a GRANT state forwards presses.
  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_press   = '0;
    case (r_state)
      StGrantHw: begin
        w_press = w_hw_press;
        if (io_led.i_sel_remote != r_src) w_state_d = StSwitchPending;
      end
      StGrantRemote: begin
        w_press = w_vio_press;
        if (io_led.i_sel_remote != r_src) w_state_d = StSwitchPending;
      end
      StSwitchPending: begin
        if (io_led.i_sel_remote == r_src) begin
          w_state_d = r_src ? StGrantRemote : StGrantHw;
        end else if (!(|w_hw_lvl) && !(|io_led.i_vio_btn)) begin
          w_src_d   = io_led.i_sel_remote;
          w_state_d = io_led.i_sel_remote ? StGrantRemote : StGrantHw;
        end
      end
      default: w_state_d = StGrantHw;
    endcase
  end

  // Mode toggle, color select with 1 > 2 > 3 priority, and auto rotation.
  always_comb begin
    w_mode_d     = r_mode ^ w_press[0];
    w_color_d    = r_color;
    w_tick_cnt_d = r_tick_cnt;
    if (|w_press[3:1]) begin
      // A manual color press wins over a coinciding auto step.
      if (w_press[1])      w_color_d = 3'b001;
      else if (w_press[2]) w_color_d = 3'b010;
      else                 w_color_d = 3'b100;
      w_tick_cnt_d = '0;
    end else if (!io_led.i_auto || (r_color == 3'b000)) begin
      w_tick_cnt_d = '0;
    end else if (io_led.i_tick) begin
      if (r_tick_cnt == TICK_LAST) begin
        w_tick_cnt_d = '0;
        w_color_d    = {r_color[1:0], r_color[2]};
      end else begin
        w_tick_cnt_d = r_tick_cnt + TW'(1);
      end
    end
  end

  // Registered control state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StGrantHw;
      r_src      <= 1'b0;
      r_mode     <= 1'b0;
      r_color    <= 3'b000;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_src      <= w_src_d;
      r_mode     <= w_mode_d;
      r_color    <= w_color_d;
      r_tick_cnt <= w_tick_cnt_d;
    end
  end

  assign io_led.o_mode   = r_mode;
  assign io_led.o_color  = r_color;
  assign io_led.o_src    = r_src;
  assign io_led.o_status = {r_color, r_mode};

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: remote press vector table plus
// directed sequences for auto rotation, source switching and reset.
module tb_led_mode_ctrl;

  localparam int DB = 4;
  localparam int AT = 8;
  localparam int NB = 4;
`ifdef LED_MODE_CTRL_DEBOUNCE_EN
  localparam int HW_LAT = 3 + DB;
`else
  localparam int HW_LAT = 3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  led_mode_ctrl_if #(.NB_BTN(NB)) u_if ();

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_TICKS     (AT),
    .NB_BTN         (NB)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .io_led(u_if)
  );

  typedef struct {
    string      name;
    logic [3:0] status;
    logic       src;
  } exp_t;

  typedef struct {
    logic [3:0] vio;
    logic [3:0] status;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input string name, input logic [3:0] status, input logic src);
    exp_t e;
    e.name = name;
    e.status = status;
    e.src = src;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (u_if.o_status !== e.status || u_if.o_src !== e.src) begin
        n_bad++;
        $display("FAIL %s: got status=%b src=%b, required status=%b src=%b",
                 e.name, u_if.o_status, u_if.o_src, e.status, e.src);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      u_if.i_tick = 1'b1;
      cyc(1);
      u_if.i_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.i_hw_btn     = '0;
    u_if.i_vio_btn    = '0;
    u_if.i_sel_remote = 1'b0;
    u_if.i_tick       = 1'b0;
    u_if.i_auto       = 1'b0;

    // Remote press table, starting from status 0001 (mode 1, color off).
    vecs[0] = '{4'b0010, 4'b0011};
    vecs[1] = '{4'b0100, 4'b0101};
    vecs[2] = '{4'b1000, 4'b1001};
    vecs[3] = '{4'b0110, 4'b0011};
    vecs[4] = '{4'b1100, 4'b0101};
    vecs[5] = '{4'b0011, 4'b0010};
    vecs[6] = '{4'b1001, 4'b1001};
    vecs[7] = '{4'b1111, 4'b0010};
    vecs[8] = '{4'b0000, 4'b0010};
    vecs[9] = '{4'b0001, 4'b0011};

    cyc(3);
    push("reset_state", 4'b0000, 1'b0);
    pop_check();

    // Request remote: one edge into pending, one edge to grant.
    u_if.i_sel_remote = 1'b1;
    reset = 1'b0;
    push("arb_pending", 4'b0000, 1'b0);
    cyc(1);
    pop_check();
    push("arb_remote", 4'b0000, 1'b1);
    cyc(1);
    pop_check();

    // Held remote button 0: exactly one toggle.
    u_if.i_vio_btn = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      push("hold_mode", 4'b0001, 1'b1);
      cyc(1);
      pop_check();
    end
    u_if.i_vio_btn = 4'b0000;
    cyc(1);

    for (int i = 0; i < 10; i++) begin
      u_if.i_vio_btn = vecs[i].vio;
      push($sformatf("vec%0d_press", i), vecs[i].status, 1'b1);
      cyc(1);
      pop_check();
      u_if.i_vio_btn = 4'b0000;
      push($sformatf("vec%0d_release", i), vecs[i].status, 1'b1);
      cyc(1);
      pop_check();
    end

    // Auto rotation r -> g -> b -> r every AT ticks.
    u_if.i_auto = 1'b1;
    cyc(1);
    push("auto_7", 4'b0011, 1'b1);
    ticks(7);
    pop_check();
    push("auto_8", 4'b0101, 1'b1);
    ticks(1);
    pop_check();
    push("auto_16", 4'b1001, 1'b1);
    ticks(8);
    pop_check();
    push("auto_24", 4'b0011, 1'b1);
    ticks(8);
    pop_check();
    ticks(7);
    u_if.i_tick    = 1'b1;
    u_if.i_vio_btn = 4'b1000;
    push("auto_manual_wins", 4'b1001, 1'b1);
    cyc(1);
    pop_check();
    u_if.i_tick    = 1'b0;
    u_if.i_vio_btn = 4'b0000;
    cyc(1);
    push("auto_cnt_cleared", 4'b1001, 1'b1);
    ticks(7);
    pop_check();
    push("auto_b_to_r", 4'b0011, 1'b1);
    ticks(1);
    pop_check();
    ticks(4);
    u_if.i_auto = 1'b0;
    cyc(1);
    u_if.i_auto = 1'b1;
    cyc(1);
    push("auto_off_clears", 4'b0011, 1'b1);
    ticks(4);
    pop_check();
    u_if.i_auto = 1'b0;

    // Pending switch cancelled by returning the select.
    u_if.i_vio_btn = 4'b0010;
    cyc(1);
    u_if.i_sel_remote = 1'b0;
    push("pend_hold", 4'b0011, 1'b1);
    cyc(2);
    pop_check();
    u_if.i_sel_remote = 1'b1;
    cyc(1);
    u_if.i_vio_btn = 4'b0000;
    cyc(1);
    u_if.i_vio_btn = 4'b0100;
    push("pend_cancel", 4'b0101, 1'b1);
    cyc(1);
    pop_check();
    u_if.i_vio_btn = 4'b0000;
    cyc(1);

    // Switch to hardware blocked while remote btn2 held; hw presses ignored.
    u_if.i_vio_btn = 4'b0100;
    cyc(1);
    u_if.i_sel_remote = 1'b0;
    push("sw_wait", 4'b0101, 1'b1);
    cyc(3);
    pop_check();
    u_if.i_hw_btn = 4'b1000;
    push("sw_hw_ignored", 4'b0101, 1'b1);
    cyc(HW_LAT + 2);
    pop_check();
    u_if.i_hw_btn = 4'b0000;
    cyc(HW_LAT + 2);
    u_if.i_vio_btn = 4'b0000;
    push("sw_done", 4'b0101, 1'b0);
    cyc(1);
    pop_check();

    // Hardware press latency.
    u_if.i_hw_btn = 4'b1000;
    push("hw_early", 4'b0101, 1'b0);
    cyc(HW_LAT - 1);
    pop_check();
    push("hw_press", 4'b1001, 1'b0);
    cyc(1);
    pop_check();
    u_if.i_hw_btn = 4'b0000;
    cyc(HW_LAT + 2);

    // Bouncing mode+color press yields a single press.
`ifdef LED_MODE_CTRL_DEBOUNCE_EN
    u_if.i_hw_btn = 4'b0011;
    cyc(1);
    u_if.i_hw_btn = 4'b0000;
    cyc(1);
`endif
    u_if.i_hw_btn = 4'b0011;
    push("hw_bounce_early", 4'b1001, 1'b0);
    cyc(HW_LAT - 1);
    pop_check();
    push("hw_bounce_press", 4'b0010, 1'b0);
    cyc(1);
    pop_check();
    push("hw_single_press", 4'b0010, 1'b0);
    cyc(4);
    pop_check();
    u_if.i_hw_btn = 4'b0000;
    cyc(HW_LAT + 2);

    // Reset during pending switch with a hw button held.
    u_if.i_sel_remote = 1'b1;
    u_if.i_vio_btn    = 4'b0001;
    u_if.i_hw_btn     = 4'b0001;
    push("pend_hw_ignored", 4'b0010, 1'b0);
    cyc(HW_LAT + 3);
    pop_check();
    reset = 1'b1;
    u_if.i_sel_remote = 1'b0;
    u_if.i_vio_btn    = 4'b0000;
    push("reset_override", 4'b0000, 1'b0);
    cyc(1);
    pop_check();
    cyc(1);
    reset = 1'b0;
    push("held_through_reset", 4'b0000, 1'b0);
    cyc(HW_LAT + 5);
    pop_check();
    u_if.i_hw_btn = 4'b0000;
    cyc(HW_LAT + 2);
    u_if.i_hw_btn = 4'b0001;
    push("repress_after_reset", 4'b0001, 1'b0);
    cyc(HW_LAT);
    pop_check();
    u_if.i_hw_btn = 4'b0000;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
